// File: rtl/iodec_seq_if.sv
// rtl/iodec_seq_if.sv - requester and decoder-side signal bundle for iodec_seq
interface iodec_seq_if;
  logic        h_req;
  logic [15:0] h_a;
  logic        h_wr;
  logic        h_ack;
  logic        g_req;
  logic [15:0] g_a;
  logic        g_wr;
  logic        g_ack;
  logic [15:0] a;
  logic        intdev;
  logic        wet;
  logic        oet;
  logic        reads;
  logic        ourack;
  logic        busy;
  logic        owner;

  modport slave (
    input  h_req, h_a, h_wr, g_req, g_a, g_wr,
    output h_ack, g_ack, a, intdev, wet, oet, reads, ourack, busy, owner
  );

  modport master (
    output h_req, h_a, h_wr, g_req, g_a, g_wr,
    input  h_ack, g_ack, a, intdev, wet, oet, reads, ourack, busy, owner
  );
endinterface

// File: rtl/iodec_seq.sv
// rtl/iodec_seq.sv - host/GPU arbiter and setup/strobe/hold sequencer for the register decoder
module iodec_seq #(
  parameter int SETUP_CYC = 1,
  parameter int STRB_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic         sys_clk,
  input  logic         resetl,
  iodec_seq_if.slave   bus
);

  if (SETUP_CYC < 0 || SETUP_CYC > 3 || STRB_CYC < 1 || STRB_CYC > 15 ||
      HOLD_CYC < 0 || HOLD_CYC > 3) begin : g_param_check
    $error("iodec_seq: timing parameter out of range");
  end

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STRB_LD  = 4'(STRB_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic        wr_q, wr_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        mask_q, mask_d;
  logic        intdev_q, wet_q, oet_q, reads_q, ourack_q, h_ack_q, g_ack_q, busy_q;
  logic        h_elig, g_elig, grant_g;

  // mask_q marks the first IDLE cycle after ACK; last_q then names the requester just served
  assign h_elig  = bus.h_req && !(mask_q && !last_q);
  assign g_elig  = bus.g_req && !(mask_q && last_q);
  assign grant_g = g_elig && (!h_elig || !last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    wr_d    = wr_q;
    owner_d = owner_q;
    last_d  = last_q;
    mask_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        a_d = 16'h0000;
        if (h_elig || g_elig) begin
          a_d     = grant_g ? bus.g_a  : bus.h_a;
          wr_d    = grant_g ? bus.g_wr : bus.h_wr;
          owner_d = grant_g;
          last_d  = grant_g;
          if (SETUP_CYC > 0) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = STRB_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = STRB_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          if (HOLD_CYC > 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_ACK;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        a_d     = 16'h0000;
        mask_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        a_d     = 16'h0000;
      end
    endcase
  end

  // Outputs are decoded from the next state so every one of them leaves a flop
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= 16'h0000;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      mask_q   <= 1'b0;
      intdev_q <= 1'b0;
      wet_q    <= 1'b0;
      oet_q    <= 1'b0;
      reads_q  <= 1'b0;
      ourack_q <= 1'b0;
      h_ack_q  <= 1'b0;
      g_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      wr_q     <= wr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      mask_q   <= mask_d;
      intdev_q <= (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      wet_q    <= (state_d == ST_STROBE) && wr_d;
      oet_q    <= (state_d == ST_STROBE) && !wr_d;
      reads_q  <= (state_d == ST_STROBE) && !wr_d;
      ourack_q <= (state_d == ST_ACK);
      h_ack_q  <= (state_d == ST_ACK) && !owner_d;
      g_ack_q  <= (state_d == ST_ACK) && owner_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign bus.a      = a_q;
  assign bus.intdev = intdev_q;
  assign bus.wet    = wet_q;
  assign bus.oet    = oet_q;
  assign bus.reads  = reads_q;
  assign bus.ourack = ourack_q;
  assign bus.h_ack  = h_ack_q;
  assign bus.g_ack  = g_ack_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;

endmodule
